// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register width, latency classes,
// and the tracked per-stage writer entry.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
  localparam int FWD_REGFILE = 0;
  localparam int LAT_ALU = 0;
  localparam int LAT_LOAD = 1;
  // Countdown storage width; LAT_W must not exceed it
  localparam int CNT_W = 8;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dest;
    logic [CNT_W-1:0] cnt;
  } entry_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side bundle for the hazard scoreboard (master = decode, slave = unit).
// Stats ports exist only when SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int LAT_W = 3,
  parameter int SEL_W = $clog2(DEPTH)
);
  logic                    flush;
  logic                    id_valid;
  logic [NSRC*REG_W-1:0]   id_src;
  logic [NSRC-1:0]         id_src_used;
  logic                    id_wen;
  logic [REG_W-1:0]        id_dest;
  logic [LAT_W-1:0]        id_lat;
  logic                    id_hilo_use;
  logic                    id_md_start;
  logic                    md_complete;
  logic                    stall;
  logic                    id_issue;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic                    hilo_busy;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]             stall_cnt;
  logic [31:0]             fwd_cnt;
`endif

  modport master (
    output flush, id_valid, id_src, id_src_used, id_wen,
    output id_dest, id_lat, id_hilo_use, id_md_start, md_complete,
`ifdef SCOREBOARD_STATS_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  stall, id_issue, fwd_sel, hilo_busy
  );

  modport slave (
    input  flush, id_valid, id_src, id_src_used, id_wen,
    input  id_dest, id_lat, id_hilo_use, id_md_start, md_complete,
`ifdef SCOREBOARD_STATS_EN
    output stall_cnt, fwd_cnt,
`endif
    output stall, id_issue, fwd_sel, hilo_busy
  );
endinterface

// File: rtl/hazard_scoreboard_src_match.sv
// Priority match of one source operand against all tracked stages;
// the youngest (lowest-index) writer decides hazard vs forward select.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [REG_W-1:0]   src_i,
  input  logic               used_i,
  input  entry_t [DEPTH-1:0] ents_i,
  output logic               hazard_o,
  output logic [SEL_W-1:0]   sel_o
);
  always_comb begin
    hazard_o = 1'b0;
    sel_o    = SEL_W'(FWD_REGFILE);
    if (used_i && src_i != ZERO_REG) begin
      // Scan oldest to youngest so the youngest hit overwrites
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ents_i[k].v && ents_i[k].dest == src_i) begin
          hazard_o = (k == 0) || (ents_i[k].cnt != '0);
          sel_o    = hazard_o ? SEL_W'(FWD_REGFILE) : SEL_W'(k);
        end
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for DEPTH post-ID stages plus HI/LO busy.
// Optional counters enabled by SCOREBOARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int LAT_W = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               resetn,
  hazard_scoreboard_if.slave sb
);
  entry_t [DEPTH-1:0]    ents_q, ents_d;
  logic                  hilo_q, hilo_d;
  logic [NSRC-1:0]       hz;
  logic [NSRC*SEL_W-1:0] fwd;
  logic                  stall;
  logic                  issue;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    hazard_src_match #(
      .DEPTH(DEPTH),
      .SEL_W(SEL_W)
    ) u_match (
      .src_i   (sb.id_src[REG_W*s +: REG_W]),
      .used_i  (sb.id_src_used[s]),
      .ents_i  (ents_q),
      .hazard_o(hz[s]),
      .sel_o   (fwd[SEL_W*s +: SEL_W])
    );
  end

  // Registered busy flag: a consumer in the completion cycle still stalls
  assign stall = sb.id_valid & ~sb.flush &
                 ((|hz) | ((sb.id_hilo_use | sb.id_md_start) & hilo_q));
  assign issue = sb.id_valid & ~stall & ~sb.flush;

  always_comb begin
    ents_d[0].v    = issue & sb.id_wen & (sb.id_dest != ZERO_REG);
    ents_d[0].dest = sb.id_dest;
    ents_d[0].cnt  = CNT_W'(sb.id_lat);
    for (int k = 1; k < DEPTH; k++) begin
      ents_d[k]   = ents_q[k-1];
      ents_d[k].v = ents_q[k-1].v & ~sb.flush;
      if (ents_q[k-1].cnt != '0)
        ents_d[k].cnt = ents_q[k-1].cnt - CNT_W'(1);
    end
  end

  always_comb begin
    hilo_d = hilo_q;
    if (issue & sb.id_md_start)
      hilo_d = 1'b1;
    else if (sb.md_complete)
      hilo_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ents_q <= '0;
      hilo_q <= 1'b0;
    end else begin
      ents_q <= ents_d;
      hilo_q <= hilo_d;
    end
  end

  assign sb.stall     = stall;
  assign sb.id_issue  = issue;
  assign sb.fwd_sel   = fwd;
  assign sb.hilo_busy = hilo_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (issue && (|fwd) && !(&fwd_cnt_q))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign sb.stall_cnt = stall_cnt_q;
  assign sb.fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench: model tracks issued writers by issue cycle.
// Set SCOREBOARD_STATS_EN to also check the counters.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int LAT_W = 3;
  localparam int SEL_W = $clog2(DEPTH);
  localparam int NCYC  = 3000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(
    .NSRC(NSRC), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W)
  ) bus ();

  hazard_scoreboard #(
    .NSRC(NSRC), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .sb    (bus)
  );

  typedef struct {
    int cyc;
    int dest;
    int lat;
  } rec_t;

  typedef struct {
    int                    cyc;
    logic                  stall;
    logic                  issue;
    logic [NSRC*SEL_W-1:0] fwd;
    logic                  hilo;
    int                    scnt;
    int                    fcnt;
  } exp_t;

  rec_t recs[$];
  exp_t expq[$];
  int   kill_before = 0;
  bit   hilo_m = 0;
  int   scnt_m = 0;
  int   fcnt_m = 0;
  int   errors = 0;
  int   checks = 0;

  // A writer issued in cycle c sits in stage t-1-c during cycle t,
  // with t-1-c cycles of its latency already elapsed.
  function automatic void lookup(input int t, input int src,
                                 output bit hz, output int sel);
    hz  = 0;
    sel = 0;
    if (src == 0) return;
    for (int k = 0; k < DEPTH; k++) begin
      int c;
      c = t - 1 - k;
      if (c < kill_before) return;
      foreach (recs[i]) begin
        if (recs[i].cyc == c && recs[i].dest == src) begin
          hz  = (k == 0) || (recs[i].lat > k);
          sel = hz ? 0 : k;
          return;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input int cyc,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("stall", e.cyc, 64'(bus.stall), 64'(e.stall));
      chk("id_issue", e.cyc, 64'(bus.id_issue), 64'(e.issue));
      chk("hilo_busy", e.cyc, 64'(bus.hilo_busy), 64'(e.hilo));
      if (!e.stall)
        chk("fwd_sel", e.cyc, 64'(bus.fwd_sel), 64'(e.fwd));
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cnt", e.cyc, 64'(bus.stall_cnt), 64'(e.scnt));
      chk("fwd_cnt", e.cyc, 64'(bus.fwd_cnt), 64'(e.fcnt));
`endif
    end
  end

  function automatic exp_t predict(input int t);
    exp_t e;
    bit   hz_any;
    e.cyc  = t;
    e.fwd  = '0;
    hz_any = 0;
    for (int s = 0; s < NSRC; s++) begin
      bit h;
      int sel;
      if (bus.id_src_used[s]) begin
        lookup(t, int'(bus.id_src[REG_W*s +: REG_W]), h, sel);
        hz_any = hz_any | h;
        e.fwd[SEL_W*s +: SEL_W] = SEL_W'(sel);
      end
    end
    e.stall = bus.id_valid && !bus.flush &&
              (hz_any || ((bus.id_hilo_use || bus.id_md_start) && hilo_m));
    e.issue = bus.id_valid && !e.stall && !bus.flush;
    e.hilo  = hilo_m;
    e.scnt  = scnt_m;
    e.fcnt  = fcnt_m;
    return e;
  endfunction

  task automatic drive_idle();
    bus.flush       = 1'b0;
    bus.id_valid    = 1'b1;
    bus.id_src      = '0;
    bus.id_src_used = '0;
    bus.id_wen      = 1'b0;
    bus.id_dest     = '0;
    bus.id_lat      = '0;
    bus.id_hilo_use = 1'b0;
    bus.id_md_start = 1'b0;
    bus.md_complete = 1'b0;
  endtask

  task automatic drive_rand();
    int r;
    resetn       = ($urandom_range(0, 299) != 0);
    bus.id_valid = ($urandom_range(0, 99) < 85);
    bus.flush    = ($urandom_range(0, 15) == 0);
    for (int s = 0; s < NSRC; s++) begin
      bus.id_src[REG_W*s +: REG_W] = REG_W'($urandom_range(0, 4));
      bus.id_src_used[s]           = ($urandom_range(0, 3) != 0);
    end
    bus.id_wen  = ($urandom_range(0, 3) != 0);
    bus.id_dest = REG_W'($urandom_range(0, 4));
    r = $urandom_range(0, 99);
    if (r < 50)
      bus.id_lat = LAT_W'(LAT_ALU);
    else if (r < 80)
      bus.id_lat = LAT_W'(LAT_LOAD);
    else
      bus.id_lat = LAT_W'($urandom_range(2, 4));
    bus.id_hilo_use = ($urandom_range(0, 7) == 0);
    bus.id_md_start = ($urandom_range(0, 9) == 0);
    bus.md_complete = ($urandom_range(0, 11) == 0);
  endtask

  task automatic commit(input int t, input exp_t e);
    if (!resetn) begin
      recs.delete();
      kill_before = t + 1;
      hilo_m = 0;
      scnt_m = 0;
      fcnt_m = 0;
    end else begin
      if (bus.flush) kill_before = t;
      if (e.issue && bus.id_wen && bus.id_dest != 0)
        recs.push_back('{t, int'(bus.id_dest), int'(bus.id_lat)});
      if (e.issue && bus.id_md_start)
        hilo_m = 1;
      else if (bus.md_complete)
        hilo_m = 0;
      if (e.stall) scnt_m++;
      if (e.issue && e.fwd != '0) fcnt_m++;
    end
    while (recs.size() > 0 && recs[0].cyc < t - DEPTH)
      void'(recs.pop_front());
  endtask

  initial begin
    exp_t e;
    drive_idle();
    resetn = 1'b0;
    #1;
    for (int t = 0; t < NCYC; t++) begin
      if (t < 2) begin
        resetn = 1'b0;
        drive_idle();
      end else begin
        drive_rand();
      end
      e = predict(t);
      if (t > 0) expq.push_back(e);
      @(posedge clk);
      #1;
      commit(t, e);
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++)
      @(negedge clk);
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
